cpu_run_ctrl: RTL and testbench

Run/halt/single-step sequencer for the single-cycle RISC-V core. It produces the core's clock enable `cpu_en`, which gates the PC register, register-file write and data-memory write. It halts the core on a halt request, an EBREAK, an ECALL or a PC breakpoint, and counts retired instructions. It sits between the board inputs (debounced buttons, switches) and the processor top, and feeds status to the LED/SSD debug view.

---
 rtl/cpu_run_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run/halt/single-step sequencer for the single-cycle RISC-V core. Generates
// the core clock enable (gates PC, register-file write and data-memory write),
// halts on a halt request, EBREAK, ECALL or PC breakpoint, and counts retired
// instructions for the debug view.
//
// Parameters
//   HOLD_CYCLES  cycles cpu_en stays low after reset release (1..15)
//
// Configuration macro
//   CPU_RUN_CTRL_BP_EN  defined: PC breakpoint comparator and skip_bp present.
//                       undefined: bp_hit tied 0, bp_addr/bp_en unused.
//
// Ports
//   clk         in   core clock
//   reset       in   asynchronous, active-low reset
//   run_req     in   pulse: resume free-running execution
//   halt_req    in   pulse: stop before the next instruction
//   step_req    in   pulse: execute one instruction, then halt
//   is_ebreak   in   current instruction is EBREAK
//   is_ecall    in   current instruction is ECALL
//   pc          in   [31:0] current PC
//   bp_addr     in   [31:0] breakpoint address (bits [1:0] ignored)
//   bp_en       in   breakpoint enable level
//   clr_cnt     in   synchronous clear of retired
//   cpu_en      out  core clock enable (combinational)
//   halted      out  registered, 1 in HALT
//   state       out  [1:0] HOLD=0 RUN=1 HALT=2 STEP=3
//   halt_cause  out  [2:0] 0 none 1 request 2 ebreak 3 ecall 4 bp 5 step
//   retired     out  [31:0] retired-instruction count
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        is_ebreak,
  input  logic        is_ecall,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  input  logic        clr_cnt,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [2:0]  halt_cause,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_REQ  = 3'd1,
    CAUSE_EBRK = 3'd2,
    CAUSE_ECAL = 3'd3,
    CAUSE_BP   = 3'd4,
    CAUSE_STEP = 3'd5
  } cause_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t      r_state;
  cause_t      r_cause;
  logic [3:0]  r_hold_cnt;
  logic        r_halted;
  logic [31:0] r_retired;

  logic        w_bp_hit;
  logic        w_stop;
  logic        w_cpu_en;
  cause_t      w_stop_cause;

`ifdef CPU_RUN_CTRL_BP_EN
  logic r_skip_bp;
  logic w_unused_lsb;

  // Word-aligned compare; skip_bp masks the hit for the instruction the core
  // is resuming on so a breakpoint does not immediately re-trigger.
  assign w_bp_hit     = bp_en & (pc[31:2] == bp_addr[31:2]) & ~r_skip_bp;
  assign w_unused_lsb = ^{pc[1:0], bp_addr[1:0]};

  // Armed on any exit from HALT, disarmed by the first enabled cycle. A
  // stopped (disabled) first RUN cycle leaves it armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skip_bp <= 1'b0;
    end else if (r_state == ST_HALT && (run_req || step_req)) begin
      r_skip_bp <= 1'b1;
    end else if (w_cpu_en) begin
      r_skip_bp <= 1'b0;
    end
  end
`else
  logic w_unused_bp;

  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = ^{pc, bp_addr, bp_en};
`endif

  assign w_stop = halt_req | is_ebreak | is_ecall | w_bp_hit;

  always_comb begin
    w_stop_cause = CAUSE_BP;
    if (halt_req)       w_stop_cause = CAUSE_REQ;
    else if (is_ebreak) w_stop_cause = CAUSE_EBRK;
    else if (is_ecall)  w_stop_cause = CAUSE_ECAL;
  end

  // STEP enables unconditionally, even on EBREAK/ECALL.
  always_comb begin
    w_cpu_en = 1'b0;
    case (r_state)
      ST_RUN:  w_cpu_en = ~w_stop;
      ST_STEP: w_cpu_en = 1'b1;
      default: w_cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= HOLD_INIT;
      r_halted   <= 1'b0;
      r_cause    <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == 4'd0) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_cause  <= CAUSE_NONE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        ST_RUN: begin
          if (w_stop) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_cause  <= w_stop_cause;
          end
        end
        ST_HALT: begin
          // halt_req is a no-op here; step wins over run.
          if (step_req) begin
            r_state  <= ST_STEP;
            r_halted <= 1'b0;
          end else if (run_req) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        ST_STEP: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
          r_cause  <= CAUSE_STEP;
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  // Clear has priority; an increment in the same cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (clr_cnt) begin
      r_retired <= '0;
    end else if (w_cpu_en) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign cpu_en     = w_cpu_en;
  assign halted     = r_halted;
  assign state      = r_state;
  assign halt_cause = r_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  // Request bits: {run, halt, step, ebreak, ecall, clr_cnt, bp_en}
  localparam logic [6:0] NO  = 7'h00;
  localparam logic [6:0] RUN = 7'h40;
  localparam logic [6:0] HLT = 7'h20;
  localparam logic [6:0] STP = 7'h10;
  localparam logic [6:0] EBK = 7'h08;
  localparam logic [6:0] ECL = 7'h04;
  localparam logic [6:0] CLR = 7'h02;
  localparam logic [6:0] BPE = 7'h01;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  typedef struct {
    logic [6:0]  req;
    logic [31:0] pc;
    logic        en;   // cpu_en before the edge
    logic [1:0]  st;   // outputs after the edge
    logic        hl;
    logic [2:0]  cs;
    logic [31:0] ret;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_req, halt_req, step_req, is_ebreak, is_ecall, bp_en, clr_cnt;
  logic [31:0] pc, bp_addr;
  logic        cpu_en, halted;
  logic [1:0]  state;
  logic [2:0]  halt_cause;
  logic [31:0] retired;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_run_ctrl #(.HOLD_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .is_ebreak (is_ebreak),
    .is_ecall  (is_ecall),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .clr_cnt   (clr_cnt),
    .cpu_en    (cpu_en),
    .halted    (halted),
    .state     (state),
    .halt_cause(halt_cause),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [6:0] req, input logic [31:0] pcv,
                             input logic en, input logic [1:0] st, input logic hl,
                             input logic [2:0] cs, input logic [31:0] ret);
    vec_t t;
    t.req = req; t.pc = pcv; t.en = en; t.st = st; t.hl = hl; t.cs = cs; t.ret = ret;
    return t;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic apply(input vec_t t, input int id);
    {run_req, halt_req, step_req, is_ebreak, is_ecall, clr_cnt, bp_en} = t.req;
    pc = t.pc;
    #1;
    chk("cpu_en", id, {31'b0, cpu_en}, {31'b0, t.en});
    @(posedge clk);
    #1;
    chk("state",      id, {30'b0, state},      {30'b0, t.st});
    chk("halted",     id, {31'b0, halted},     {31'b0, t.hl});
    chk("halt_cause", id, {29'b0, halt_cause}, {29'b0, t.cs});
    chk("retired",    id, retired,             t.ret);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] rb;

    // HOLD with requests ignored, then HALT after 4 edges
    tbl.push_back(v(NO,  0, 0, S_HOLD, 0, 0, 0));
    tbl.push_back(v(RUN, 0, 0, S_HOLD, 0, 0, 0));
    tbl.push_back(v(STP, 0, 0, S_HOLD, 0, 0, 0));
    tbl.push_back(v(NO,  0, 0, S_HALT, 1, 0, 0));
    // run 10 cycles then halt
    tbl.push_back(v(RUN, 0, 0, S_RUN, 0, 0, 0));
    for (int i = 1; i <= 10; i++) tbl.push_back(v(NO, 0, 1, S_RUN, 0, 0, 32'(i)));
    tbl.push_back(v(HLT, 0, 0, S_HALT, 1, 1, 10));
    tbl.push_back(v(HLT, 0, 0, S_HALT, 1, 1, 10));
    // three spaced steps; step beats run; halt/ebreak do not cancel a step
    tbl.push_back(v(STP,       0, 0, S_STEP, 0, 1, 10));
    tbl.push_back(v(NO,        0, 1, S_HALT, 1, 5, 11));
    tbl.push_back(v(NO,        0, 0, S_HALT, 1, 5, 11));
    tbl.push_back(v(STP,       0, 0, S_STEP, 0, 5, 11));
    tbl.push_back(v(NO,        0, 1, S_HALT, 1, 5, 12));
    tbl.push_back(v(NO,        0, 0, S_HALT, 1, 5, 12));
    tbl.push_back(v(STP | RUN, 0, 0, S_STEP, 0, 5, 12));
    tbl.push_back(v(HLT | EBK, 0, 1, S_HALT, 1, 5, 13));
    tbl.push_back(v(NO,        0, 0, S_HALT, 1, 5, 13));
    // cause priority
    tbl.push_back(v(RUN,       0, 0, S_RUN,  0, 5, 13));
    tbl.push_back(v(HLT | EBK, 0, 0, S_HALT, 1, 1, 13));
    tbl.push_back(v(RUN | ECL, 0, 0, S_RUN,  0, 1, 13));
    tbl.push_back(v(ECL,       0, 0, S_HALT, 1, 3, 13));
    tbl.push_back(v(RUN,       0, 0, S_RUN,  0, 3, 13));
    tbl.push_back(v(EBK | ECL, 0, 0, S_HALT, 1, 2, 13));
    // clear beats increment
    tbl.push_back(v(RUN,       0, 0, S_RUN,  0, 2, 13));
    tbl.push_back(v(NO,        0, 1, S_RUN,  0, 2, 14));
    tbl.push_back(v(CLR,       0, 1, S_RUN,  0, 2, 0));
    tbl.push_back(v(NO,        0, 1, S_RUN,  0, 2, 1));
    tbl.push_back(v(CLR | HLT, 0, 0, S_HALT, 1, 1, 0));
    // held step_req steps every other cycle
    tbl.push_back(v(STP, 0, 0, S_STEP, 0, 1, 0));
    tbl.push_back(v(STP, 0, 1, S_HALT, 1, 5, 1));
    tbl.push_back(v(STP, 0, 0, S_STEP, 0, 5, 1));
    tbl.push_back(v(STP, 0, 1, S_HALT, 1, 5, 2));
    // breakpoint at 0x13 (low bits ignored -> matches pc 0x10)
    tbl.push_back(v(RUN | BPE, 32'h0, 0, S_RUN, 0, 5, 2));
    tbl.push_back(v(BPE, 32'h0, 1, S_RUN, 0, 5, 3));
    tbl.push_back(v(BPE, 32'h4, 1, S_RUN, 0, 5, 4));
    tbl.push_back(v(BPE, 32'h8, 1, S_RUN, 0, 5, 5));
    tbl.push_back(v(BPE, 32'hC, 1, S_RUN, 0, 5, 6));
    if (BP) begin
      tbl.push_back(v(BPE,       32'h10, 0, S_HALT, 1, 4, 6));
      tbl.push_back(v(RUN | BPE, 32'h10, 0, S_RUN,  0, 4, 6));
      tbl.push_back(v(BPE,       32'h10, 1, S_RUN,  0, 4, 7));
      tbl.push_back(v(BPE,       32'h14, 1, S_RUN,  0, 4, 8));
      tbl.push_back(v(BPE,       32'h10, 0, S_HALT, 1, 4, 8));
      tbl.push_back(v(RUN,       32'h0,  0, S_RUN,  0, 4, 8));
      tbl.push_back(v(HLT,       32'h0,  0, S_HALT, 1, 1, 8));
      rb = 8;
    end else begin
      tbl.push_back(v(BPE,       32'h10, 1, S_RUN,  0, 5, 7));
      tbl.push_back(v(RUN | BPE, 32'h10, 1, S_RUN,  0, 5, 8));
      tbl.push_back(v(BPE,       32'h10, 1, S_RUN,  0, 5, 9));
      tbl.push_back(v(BPE,       32'h14, 1, S_RUN,  0, 5, 10));
      tbl.push_back(v(BPE,       32'h10, 1, S_RUN,  0, 5, 11));
      tbl.push_back(v(HLT,       32'h0,  0, S_HALT, 1, 1, 11));
      rb = 11;
    end

    reset = 1'b0;
    {run_req, halt_req, step_req, is_ebreak, is_ecall, clr_cnt, bp_en} = '0;
    pc = '0;
    bp_addr = 32'h13;

    #3;
    chk("rst_cpu_en",  -1, {31'b0, cpu_en},     32'd0);
    chk("rst_state",   -1, {30'b0, state},      32'd0);
    chk("rst_halted",  -1, {31'b0, halted},     32'd0);
    chk("rst_cause",   -1, {29'b0, halt_cause}, 32'd0);
    chk("rst_retired", -1, retired,             32'd0);

    @(negedge clk);
    reset = 1'b1;
    foreach (tbl[i]) apply(tbl[i], i);

    // counter wrap: preload all-ones while halted, then one step
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    apply(v(STP, 0, 0, S_STEP, 0, 1, 32'hFFFF_FFFF), 100);
    apply(v(NO,  0, 1, S_HALT, 1, 5, 32'h0),         101);
    apply(v(STP, 0, 0, S_STEP, 0, 5, 0),             102);
    apply(v(NO,  0, 1, S_HALT, 1, 5, 1),             103);
    apply(v(STP, 0, 0, S_STEP, 0, 5, 1),             104);
    apply(v(CLR, 0, 1, S_HALT, 1, 5, 0),             105);
    apply(v(RUN, 0, 0, S_RUN,  0, 5, 0),             106);
    apply(v(NO,  0, 1, S_RUN,  0, 5, 1),             107);

    // reset asserted mid-RUN: enable drops without waiting for an edge
    {run_req, halt_req, step_req, is_ebreak, is_ecall, clr_cnt, bp_en} = '0;
    #1;
    chk("pre_rst_cpu_en", 108, {31'b0, cpu_en}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_cpu_en",  108, {31'b0, cpu_en},     32'd0);
    chk("async_state",   108, {30'b0, state},      32'd0);
    chk("async_retired", 108, retired,             32'd0);
    chk("async_cause",   108, {29'b0, halt_cause}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    apply(v(NO,  0, 0, S_HOLD, 0, 0, 0), 110);
    apply(v(RUN, 0, 0, S_HOLD, 0, 0, 0), 111);
    apply(v(NO,  0, 0, S_HOLD, 0, 0, 0), 112);
    apply(v(NO,  0, 0, S_HALT, 1, 0, 0), 113);
    apply(v(RUN, 0, 0, S_RUN,  0, 0, 0), 114);
    apply(v(NO,  0, 1, S_RUN,  0, 0, 1), 115);

    if (rb == 0) n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
